// File: rtl/spi_sender_path_if.sv
// Host-side and SPI-side signals of the SPI transmit path.
// The master modport is the host/bench side; the slave modport is the sender itself.
interface spi_sender_path_if #(
    parameter int DATA_W = 8
);
    logic              SENDER_WRITE;
    logic [DATA_W-1:0] DATA_IN;
    logic              MOSI;
    logic              SPI_SCK;
    logic              CS_N;
    logic              SENDER_FULL_STATE;
    logic              SENDER_EMPTY_STATE;
    logic              SENDER_BUFFER_FULL_STATE;
    logic              SENDER_BUFFER_SH_LD;
    logic              SENDER_WRITE_REJECT;

    modport master (
        output SENDER_WRITE, DATA_IN,
        input  MOSI, SPI_SCK, CS_N, SENDER_FULL_STATE, SENDER_EMPTY_STATE,
               SENDER_BUFFER_FULL_STATE, SENDER_BUFFER_SH_LD, SENDER_WRITE_REJECT
    );

    modport slave (
        input  SENDER_WRITE, DATA_IN,
        output MOSI, SPI_SCK, CS_N, SENDER_FULL_STATE, SENDER_EMPTY_STATE,
               SENDER_BUFFER_FULL_STATE, SENDER_BUFFER_SH_LD, SENDER_WRITE_REJECT
    );
endinterface

// File: rtl/spi_sender_path.sv
// SPI master transmit path (mode 0): host FIFO feeding an MSB-first shift buffer,
// with back-to-back frames under a single chip-select assertion.
module spi_sender_path #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic              S_CLK,
    input  logic              CLR,
    spi_sender_path_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, full_q, reject_q;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sck_q, sck_d;
    logic              buf_full_q, buf_full_d;
    logic              push, pop;

    // FIFO bookkeeping; flags are registered from the next count so they line up with it
    always_comb begin
        push     = bus.SENDER_WRITE && !full_q;
        pop      = (state_q == LOAD) && !empty_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        div_d      = div_q;
        sck_d      = sck_q;
        buf_full_d = buf_full_q;
        case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                if (!empty_q) state_d = LOAD;
            end
            LOAD: begin
                shreg_d    = mem_q[rd_ptr_q];
                buf_full_d = 1'b1;
                bitcnt_d   = '0;
                div_d      = '0;
                sck_d      = 1'b0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    // Falling edge: the receiver has sampled, present the next bit
                    if (sck_q) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                        if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
                            buf_full_d = 1'b0;
                            state_d    = empty_q ? IDLE : LOAD;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            reject_q   <= 1'b0;
            bitcnt_q   <= '0;
            div_q      <= '0;
            sck_q      <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CNT_W'(DEPTH));
            reject_q   <= bus.SENDER_WRITE && full_q;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            buf_full_q <= buf_full_d;
        end
    end

    // Data storage carries no reset; MOSI is gated by state so stale bits never leak out
    always_ff @(posedge S_CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.DATA_IN;
        shreg_q <= shreg_d;
    end

    assign bus.MOSI                     = (state_q == SHIFT) && shreg_q[DATA_W-1];
    assign bus.SPI_SCK                  = sck_q;
    assign bus.CS_N                     = (state_q == IDLE);
    assign bus.SENDER_FULL_STATE        = full_q;
    assign bus.SENDER_EMPTY_STATE       = empty_q;
    assign bus.SENDER_BUFFER_FULL_STATE = buf_full_q;
    assign bus.SENDER_BUFFER_SH_LD      = (state_q != LOAD);
    assign bus.SENDER_WRITE_REJECT      = reject_q;
endmodule

// File: tb/tb_spi_sender_path.sv
// Directed bench for spi_sender_path (DATA_W=8, DEPTH=4, CLK_DIV=2).
module tb_spi_sender_path;
    logic S_CLK = 1'b0;
    logic CLR   = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 S_CLK = ~S_CLK;

    spi_sender_path_if #(.DATA_W(8)) bus ();

    spi_sender_path #(.DATA_W(8), .DEPTH(4), .CLK_DIV(2)) dut (
        .S_CLK (S_CLK),
        .CLR   (CLR),
        .bus   (bus)
    );

    // Line monitor state, refreshed once per cycle by step()
    logic       prev_sck, prev_cs;
    int         rises, falls, loads, rejects, cs_rises, viol, nrx, bitn;
    logic [7:0] sh;
    logic [7:0] rx [16];

    task automatic clear_mon();
        rises = 0; falls = 0; loads = 0; rejects = 0; cs_rises = 0; viol = 0;
        nrx = 0; bitn = 0; sh = 8'h00;
        prev_sck = bus.SPI_SCK;
        prev_cs  = bus.CS_N;
    endtask

    task automatic step();
        @(posedge S_CLK);
        #1;
        if (bus.SPI_SCK === 1'b1 && prev_sck === 1'b0) begin
            rises++;
            sh = {sh[6:0], bus.MOSI};
            bitn++;
            if (bitn == 8) begin
                if (nrx < 16) rx[nrx] = sh;
                nrx++;
                bitn = 0;
            end
        end
        if (bus.SPI_SCK === 1'b0 && prev_sck === 1'b1) falls++;
        if (bus.CS_N === 1'b1 && prev_cs === 1'b0) cs_rises++;
        if (bus.SENDER_BUFFER_SH_LD === 1'b0) loads++;
        if (bus.SENDER_WRITE_REJECT === 1'b1) rejects++;
        if (bus.CS_N === 1'b1 && bus.SPI_SCK !== 1'b0) viol++;
        prev_sck = bus.SPI_SCK;
        prev_cs  = bus.CS_N;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        int n = 0;
        while (!(bus.CS_N === 1'b1 && bus.SENDER_EMPTY_STATE === 1'b1) && n < maxc) begin
            step();
            n++;
        end
        ok = (bus.CS_N === 1'b1 && bus.SENDER_EMPTY_STATE === 1'b1);
    endtask

    task automatic wait_load(input int maxc, output bit ok);
        int n = 0;
        while (bus.SENDER_BUFFER_SH_LD !== 1'b0 && n < maxc) begin
            step();
            n++;
        end
        ok = (bus.SENDER_BUFFER_SH_LD === 1'b0);
    endtask

    function automatic logic [7:0] outs();
        return {bus.SENDER_EMPTY_STATE, bus.SENDER_FULL_STATE, bus.SENDER_BUFFER_FULL_STATE,
                bus.SENDER_BUFFER_SH_LD, bus.CS_N, bus.SPI_SCK, bus.MOSI, bus.SENDER_WRITE_REJECT};
    endfunction

    // {EMPTY,FULL,BUF_FULL,SH_LD,CS_N,SCK,MOSI,REJECT}
    localparam logic [7:0] RESET_OUTS = 8'b1001_1000;

    task automatic test_reset();
        bus.SENDER_WRITE = 1'b0;
        bus.DATA_IN      = 8'h00;
        CLR = 1'b1;
        repeat (3) step();
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++; $display("FAIL reset_outs got %b want %b", outs(), RESET_OUTS);
        end
        CLR = 1'b0;
        step();
        checks++;
        if (outs() !== RESET_OUTS) begin
            errors++; $display("FAIL reset_idle got %b want %b", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        bus.DATA_IN = 8'hA5; bus.SENDER_WRITE = 1'b1;
        step();                                   // cycle N+1
        bus.SENDER_WRITE = 1'b0;
        checks++;
        if (bus.SENDER_EMPTY_STATE !== 1'b0 || bus.CS_N !== 1'b1) begin
            errors++; $display("FAIL single_n1 empty=%b cs_n=%b want 0 1", bus.SENDER_EMPTY_STATE, bus.CS_N);
        end
        step();                                   // cycle N+2: LOAD
        checks++;
        if (bus.SENDER_BUFFER_SH_LD !== 1'b0 || bus.CS_N !== 1'b0) begin
            errors++; $display("FAIL single_load sh_ld=%b cs_n=%b want 0 0", bus.SENDER_BUFFER_SH_LD, bus.CS_N);
        end
        step();                                   // cycle N+3: first SHIFT cycle
        checks++;
        if ({bus.SENDER_BUFFER_SH_LD, bus.MOSI, bus.SENDER_BUFFER_FULL_STATE, bus.SENDER_EMPTY_STATE, bus.SPI_SCK} !== 5'b11110) begin
            errors++; $display("FAIL single_shift0 shld,mosi,bf,empty,sck=%b want 11110",
                {bus.SENDER_BUFFER_SH_LD, bus.MOSI, bus.SENDER_BUFFER_FULL_STATE, bus.SENDER_EMPTY_STATE, bus.SPI_SCK});
        end
        repeat (31) step();                       // cycle N+34: last SHIFT cycle
        checks++;
        if (bus.CS_N !== 1'b0) begin
            errors++; $display("FAIL single_cs_last got %b want 0", bus.CS_N);
        end
        step();                                   // cycle N+35: IDLE
        checks++;
        if ({bus.CS_N, bus.SPI_SCK, bus.SENDER_BUFFER_FULL_STATE} !== 3'b100) begin
            errors++; $display("FAIL single_end cs,sck,bf=%b want 100",
                {bus.CS_N, bus.SPI_SCK, bus.SENDER_BUFFER_FULL_STATE});
        end
        checks++;
        if (nrx !== 1 || rx[0] !== 8'hA5) begin
            errors++; $display("FAIL single_data frames=%0d byte=%h want 1 a5", nrx, rx[0]);
        end
        checks++;
        if (rises !== 8 || falls !== 8 || loads !== 1 || viol !== 0) begin
            errors++; $display("FAIL single_edges rises=%0d falls=%0d loads=%0d viol=%0d want 8 8 1 0",
                rises, falls, loads, viol);
        end
        repeat (5) step();
        checks++;
        if (rises !== 8 || bus.CS_N !== 1'b1) begin
            errors++; $display("FAIL single_quiet rises=%0d cs_n=%b want 8 1", rises, bus.CS_N);
        end
        ok = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        bus.DATA_IN = 8'h3C; bus.SENDER_WRITE = 1'b1;
        step();
        bus.DATA_IN = 8'hC3;
        step();
        bus.SENDER_WRITE = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout cs_n=%b empty=%b want 1 1", bus.CS_N, bus.SENDER_EMPTY_STATE);
        end
        checks++;
        if (nrx !== 2 || rx[0] !== 8'h3C || rx[1] !== 8'hC3) begin
            errors++; $display("FAIL b2b_data frames=%0d b0=%h b1=%h want 2 3c c3", nrx, rx[0], rx[1]);
        end
        checks++;
        if (loads !== 2 || rises !== 16 || cs_rises !== 1 || viol !== 0) begin
            errors++; $display("FAIL b2b_ctrl loads=%0d rises=%0d cs_rises=%0d viol=%0d want 2 16 1 0",
                loads, rises, cs_rises, viol);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [7:0] vals [6] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76};
        logic [7:0] want [5] = '{8'h11, 8'h21, 8'h32, 8'h43, 8'h54};
        clear_mon();
        bus.DATA_IN = 8'h11; bus.SENDER_WRITE = 1'b1;
        step();
        bus.SENDER_WRITE = 1'b0;
        wait_load(10, ok);
        step();                                   // FSM shifting, FIFO empty
        checks++;
        if (!ok || bus.SENDER_EMPTY_STATE !== 1'b1) begin
            errors++; $display("FAIL full_setup load_seen=%b empty=%b want 1 1", ok, bus.SENDER_EMPTY_STATE);
        end
        bus.SENDER_WRITE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.DATA_IN = vals[i];
            step();
            if (i == 2) begin
                checks++;
                if (bus.SENDER_FULL_STATE !== 1'b0) begin
                    errors++; $display("FAIL full_after3 got %b want 0", bus.SENDER_FULL_STATE);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.SENDER_FULL_STATE !== 1'b1 || bus.SENDER_WRITE_REJECT !== 1'b0) begin
                    errors++; $display("FAIL full_after4 full=%b reject=%b want 1 0",
                        bus.SENDER_FULL_STATE, bus.SENDER_WRITE_REJECT);
                end
            end
            if (i == 4) begin
                checks++;
                if (bus.SENDER_WRITE_REJECT !== 1'b1) begin
                    errors++; $display("FAIL full_reject_pulse got %b want 1", bus.SENDER_WRITE_REJECT);
                end
            end
        end
        bus.SENDER_WRITE = 1'b0;
        step();
        checks++;
        if (rejects !== 2 || bus.SENDER_WRITE_REJECT !== 1'b0) begin
            errors++; $display("FAIL full_reject_count got %0d reject=%b want 2 0", rejects, bus.SENDER_WRITE_REJECT);
        end
        wait_idle(400, ok);
        checks++;
        if (!ok || nrx !== 5) begin
            errors++; $display("FAIL full_drain idle=%b frames=%0d want 1 5", ok, nrx);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx[i] !== want[i]) begin
                errors++; $display("FAIL full_order idx=%0d got %h want %h", i, rx[i], want[i]);
            end
        end
    endtask

    task automatic test_clr_midframe();
        int n = 0;
        clear_mon();
        bus.DATA_IN = 8'h5A; bus.SENDER_WRITE = 1'b1;
        step();
        bus.DATA_IN = 8'h96;
        step();
        bus.SENDER_WRITE = 1'b0;
        while (falls < 3 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (falls !== 3) begin
            errors++; $display("FAIL clr_wait falls=%0d want 3", falls);
        end
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        checks++;
        if ({bus.CS_N, bus.SPI_SCK, bus.SENDER_EMPTY_STATE, bus.SENDER_BUFFER_FULL_STATE, bus.SENDER_BUFFER_SH_LD} !== 5'b10101) begin
            errors++; $display("FAIL clr_abort cs,sck,empty,bf,shld=%b want 10101",
                {bus.CS_N, bus.SPI_SCK, bus.SENDER_EMPTY_STATE, bus.SENDER_BUFFER_FULL_STATE, bus.SENDER_BUFFER_SH_LD});
        end
        clear_mon();
        repeat (40) step();
        checks++;
        if (rises !== 0 || falls !== 0 || loads !== 0 || bus.CS_N !== 1'b1) begin
            errors++; $display("FAIL clr_quiet rises=%0d falls=%0d loads=%0d cs_n=%b want 0 0 0 1",
                rises, falls, loads, bus.CS_N);
        end
    endtask

    task automatic test_full_pop();
        bit ok;
        logic [7:0] want [4] = '{8'h82, 8'h83, 8'h84, 8'h85};
        bus.DATA_IN = 8'h81; bus.SENDER_WRITE = 1'b1;
        step();
        bus.SENDER_WRITE = 1'b0;
        wait_load(10, ok);
        step();
        bus.SENDER_WRITE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DATA_IN = want[i];
            step();
        end
        bus.SENDER_WRITE = 1'b0;
        checks++;
        if (!ok || bus.SENDER_FULL_STATE !== 1'b1) begin
            errors++; $display("FAIL fp_setup load_seen=%b full=%b want 1 1", ok, bus.SENDER_FULL_STATE);
        end
        wait_load(60, ok);                        // LOAD of 0x82 while FIFO full
        clear_mon();
        bus.DATA_IN = 8'hEE; bus.SENDER_WRITE = 1'b1;
        step();
        bus.SENDER_WRITE = 1'b0;
        checks++;
        if (!ok || {bus.SENDER_WRITE_REJECT, bus.SENDER_FULL_STATE, bus.SENDER_EMPTY_STATE} !== 3'b100) begin
            errors++; $display("FAIL fp_flags load_seen=%b reject,full,empty=%b want 1 100",
                ok, {bus.SENDER_WRITE_REJECT, bus.SENDER_FULL_STATE, bus.SENDER_EMPTY_STATE});
        end
        wait_idle(400, ok);
        checks++;
        if (!ok || nrx !== 4 || loads !== 3) begin
            errors++; $display("FAIL fp_drain idle=%b frames=%0d loads=%0d want 1 4 3", ok, nrx, loads);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx[i] !== want[i]) begin
                errors++; $display("FAIL fp_order idx=%0d got %h want %h", i, rx[i], want[i]);
            end
        end
    endtask

    initial begin
        bus.SENDER_WRITE = 1'b0;
        bus.DATA_IN      = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_clr_midframe();
        test_full_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
